// File: rtl/median_window_filter_pkg.sv
// median_window_filter_pkg: default sizes, count width helper and fill/run state encoding
package median_window_filter_pkg;
  localparam int DEF_DATA_W = 4;
  localparam int DEF_WIN = 6;
  typedef enum logic {ST_FILL = 1'b0, ST_RUN = 1'b1} state_t;
  function automatic int cnt_w(input int win);
    return $clog2(win + 1);
  endfunction
endpackage

// File: rtl/median_window_filter_sorted_window_update.sv
// sorted_window_update: combinational delete-one-match then ordered insert on a sorted array (s_in/count/remove_en/remove_val/insert_val -> s_out)
module sorted_window_update
  import median_window_filter_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int WIN = DEF_WIN,
  localparam int CNT_W = cnt_w(WIN)
) (
  input  logic [DATA_W-1:0] s_in [WIN],
  input  logic [CNT_W-1:0]  count,
  input  logic              remove_en,
  input  logic [DATA_W-1:0] remove_val,
  input  logic [DATA_W-1:0] insert_val,
  output logic [DATA_W-1:0] s_out [WIN]
);
  logic [WIN-1:0] hit, gone;
  logic [DATA_W-1:0] r [WIN];
  logic [CNT_W-1:0] n, pos;
  logic run;
  always_comb begin
    hit = '0;
    gone = '0;
    run = 1'b0;
    for (int i = 0; i < WIN; i++) begin
      hit[i] = remove_en && !run && CNT_W'(i) < count && s_in[i] == remove_val;
      run = run | hit[i];
      gone[i] = run;
    end
    for (int i = 0; i < WIN; i++)
      r[i] = gone[i] ? ((i < WIN - 1) ? s_in[(i < WIN - 1) ? i + 1 : i] : '0) : s_in[i];
    n = count - CNT_W'(run);
    pos = '0;
    for (int i = 0; i < WIN; i++)
      pos = pos + CNT_W'(CNT_W'(i) < n && r[i] <= insert_val);
    for (int i = 0; i < WIN; i++)
      s_out[i] = CNT_W'(i) < pos ? r[i] : CNT_W'(i) == pos ? insert_val : r[(i > 0) ? i - 1 : 0];
  end
endmodule

// File: rtl/median_window_filter.sv
// median_window_filter: sliding-window median with valid/ready in and out (clk, rst, clear, in_valid/in_ready/in_data, out_valid/out_ready/median, window_full)
module median_window_filter
  import median_window_filter_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int WIN = DEF_WIN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] median,
  output logic              window_full
);
  localparam int MID_LO = (WIN - 1) / 2;
  localparam int MID_HI = WIN / 2;
  localparam int CNT_W = cnt_w(WIN);
  state_t state, state_nx;
  logic [CNT_W-1:0] count;
  logic [DATA_W-1:0] fifo [WIN];
  logic [DATA_W-1:0] srt [WIN];
  logic [DATA_W-1:0] nxt [WIN];
  logic accept, produce, last_fill;
  logic [DATA_W:0] sum;
  assign in_ready = !out_valid || out_ready;
  assign accept = in_valid && in_ready;
  assign window_full = state == ST_RUN;
  sorted_window_update #(.DATA_W(DATA_W), .WIN(WIN)) u_upd (
    .s_in(srt),
    .count(count),
    .remove_en(state == ST_RUN),
    .remove_val(fifo[0]),
    .insert_val(in_data),
    .s_out(nxt)
  );
  always_comb begin
    last_fill = state == ST_FILL && count == CNT_W'(WIN - 1);
    state_nx = (accept && last_fill) ? ST_RUN : state;
    produce = accept && (state == ST_RUN || last_fill);
    sum = {1'b0, nxt[MID_LO]} + {1'b0, nxt[MID_HI]};
  end
  always_ff @(posedge clk)
    state <= (rst || clear) ? ST_FILL : state_nx;
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
      out_valid <= 1'b0;
      median <= '0;
      for (int i = 0; i < WIN; i++) begin
        fifo[i] <= '0;
        srt[i] <= '0;
      end
    end else begin
      out_valid <= produce || (out_valid && !out_ready);
      if (produce) median <= sum[DATA_W:1];
      if (accept) begin
        if (state == ST_FILL) count <= count + CNT_W'(1);
        for (int i = 0; i < WIN; i++) begin
          srt[i] <= nxt[i];
          if (state == ST_RUN) fifo[i] <= (i == WIN - 1) ? in_data : fifo[(i < WIN - 1) ? i + 1 : i];
          else if (CNT_W'(i) == count) fifo[i] <= in_data;
        end
      end
    end
  end
endmodule

// File: tb/tb_median_window_filter.sv
// tb_median_window_filter: directed stimulus with a sorting reference model and expected-median scoreboard
module tb_median_window_filter;
  localparam int DATA_W = 4;
  localparam int WIN = 6;
  logic clk = 1'b0;
  logic rst, clear, in_valid, in_ready, out_valid, out_ready, window_full;
  logic [DATA_W-1:0] in_data, median;
  int n_checks = 0;
  int n_pass = 0;
  int win [$];
  int exp_q [$];
  int held;
  always #5 clk = ~clk;
  median_window_filter #(.DATA_W(DATA_W), .WIN(WIN)) dut (
    .clk(clk),
    .rst(rst),
    .clear(clear),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .median(median),
    .window_full(window_full)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask
  function automatic int model_med();
    int a [$];
    a = win;
    a.sort();
    return (a[(WIN - 1) / 2] + a[WIN / 2]) >> 1;
  endfunction
  task automatic model_flush();
    win.delete();
    exp_q.delete();
  endtask
  task automatic send(input logic [DATA_W-1:0] d);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data = d;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    win.push_back(int'(d));
    if (win.size() > WIN) void'(win.pop_front());
    if (win.size() == WIN) exp_q.push_back(model_med());
    if (exp_q.size() > 0) begin
      chk("out_valid", out_valid, 1);
      chk("median", median, exp_q.pop_front());
      chk("window_full", window_full, 1);
    end else chk("no_output_in_fill", out_valid, 0);
  endtask
  initial begin
    rst = 1'b1;
    clear = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_median", median, 0);
    chk("rst_window_full", window_full, 0);
    chk("rst_in_ready", in_ready, 1);
    foreach (win[i]) chk("model_empty", win.size(), 0);
    for (int i = 1; i <= 6; i++) send(DATA_W'(i));
    send(15);
    send(0);
    repeat (6) send(7);
    repeat (3) send(0);
    repeat (3) send(15);
    repeat (3) send(14);
    repeat (2) send(15);
    out_ready = 1'b0;
    held = int'(median);
    in_valid = 1'b1;
    in_data = 9;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_median", median, held);
      chk("bp_out_valid", out_valid, 1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(9);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    model_flush();
    repeat (3) send(4);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    model_flush();
    chk("clear_out_valid", out_valid, 0);
    chk("clear_window_full", window_full, 0);
    chk("clear_median", median, 0);
    repeat (6) send(2);
    in_valid = 1'b1;
    in_data = 5;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    model_flush();
    chk("rst_run_out_valid", out_valid, 0);
    chk("rst_run_window_full", window_full, 0);
    chk("rst_run_median", median, 0);
    repeat (6) send(1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
